// File: rtl/gen_sample_fifo.sv
// gen_sample_fifo: synchronous FIFO buffering signed generator samples for a consumer.
// Ports: clk, rst (async active-high); wr_en_i/data_i push a sample; rd_en_i pops one
// into the registered data_o, flagged by rd_valid_o the following cycle; clr_err_i clears
// the sticky overflow_o/underflow_o flags; full_o, empty_o, count_o report occupancy.
// Optional macro GEN_FIFO_WATERMARK_EN adds almost_full_o and almost_empty_o.
module gen_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
`ifdef GEN_FIFO_WATERMARK_EN
  output logic                  underflow_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`else
  output logic                  underflow_o
`endif
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok, ovf, unf;
  // Flags come straight from the registered pointers, so reset forces them immediately.
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o = wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]};
  assign count_o = wr_ptr - rd_ptr;
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);
  assign ovf = wr_en_i & ~wr_ok;
  assign unf = rd_en_i & empty_o;
`ifdef GEN_FIFO_WATERMARK_EN
  localparam logic [ADDR_WIDTH:0] AF = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE = AE_LEVEL[ADDR_WIDTH:0];
  assign almost_full_o = count_o >= AF;
  assign almost_empty_o = count_o <= AE;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_o <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      if (rd_ok) data_o <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      rd_valid_o <= rd_ok;
      overflow_o <= (overflow_o & ~clr_err_i) | ovf;
      underflow_o <= (underflow_o & ~clr_err_i) | unf;
    end
  // Storage is deliberately unreset; pointer reset makes old contents unreachable.
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
endmodule

// File: tb/tb_gen_sample_fifo.sv
// tb_gen_sample_fifo: randomized self-checking bench for gen_sample_fifo against a queue model.
module tb_gen_sample_fifo;
  logic clk = 0, rst = 1, wr_en_i = 0, rd_en_i = 0, clr_err_i = 0;
  logic [31:0] data_i = 0, data_o;
  logic rd_valid_o, full_o, empty_o, overflow_o, underflow_o;
  logic [4:0] count_o;
`ifdef GEN_FIFO_WATERMARK_EN
  logic almost_full_o, almost_empty_o;
`endif
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  logic [31:0] m_data = 0;
  logic m_valid = 0, m_ovf = 0, m_unf = 0;

  gen_sample_fifo dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .data_i(data_i), .rd_en_i(rd_en_i),
    .clr_err_i(clr_err_i), .data_o(data_o), .rd_valid_o(rd_valid_o), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
`ifdef GEN_FIFO_WATERMARK_EN
    .underflow_o(underflow_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
`else
    .underflow_o(underflow_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit ra, wa, was_empty;
    @(negedge clk);
    wr_en_i = w; data_i = d; rd_en_i = r; clr_err_i = c;
    was_empty = q.size() == 0;
    ra = r && !was_empty;
    wa = w && (q.size() < 16 || ra);
    m_valid = ra;
    if (ra) m_data = q.pop_front();
    if (wa) q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wa);
    m_unf = (m_unf && !c) || (r && was_empty);
    @(posedge clk);
    #1;
    wr_en_i = 0; rd_en_i = 0; clr_err_i = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_data = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty_o); end
    tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full_o); end
    tests++; if (count_o !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
    tests++; if ({rd_valid_o, overflow_o, underflow_o, data_o} !== 35'd0) begin fails++;
      $display("FAIL reset_regs got %b%b%b %h want 000 0", rd_valid_o, overflow_o, underflow_o, data_o); end
`ifdef GEN_FIFO_WATERMARK_EN
    tests++; if ({almost_full_o, almost_empty_o} !== 2'b01) begin fails++;
      $display("FAIL reset_wm got %b%b want 01", almost_full_o, almost_empty_o); end
`endif
    rst = 0;
    model_reset();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1, 32'h1000_0000 + i, 0, 0);
      tests++; if (count_o !== 5'(q.size())) begin fails++; $display("FAIL fill_count got %0d want %0d", count_o, q.size()); end
    end
    tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL fill_full got %b want 1", full_o); end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 0);
      tests++; if (rd_valid_o !== 1'b1 || data_o !== 32'h1000_0000 + i) begin fails++;
        $display("FAIL drain_data got %b %h want 1 %h", rd_valid_o, data_o, 32'h1000_0000 + i); end
    end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL drain_empty got %b want 1", empty_o); end
    cycle(0, 0, 0, 0);
    tests++; if (rd_valid_o !== 1'b0 || data_o !== 32'h1000_000F) begin fails++;
      $display("FAIL idle_hold got %b %h want 0 1000000f", rd_valid_o, data_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cycle(1, $urandom, 0, 0);
    cycle(1, 32'hDEAD_BEEF, 0, 0);
    tests++; if (overflow_o !== 1'b1 || count_o !== 5'd16) begin fails++;
      $display("FAIL overflow got ovf=%b cnt=%0d want ovf=1 cnt=16", overflow_o, count_o); end
    cycle(0, 0, 0, 0);
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %b want 1", overflow_o); end
    cycle(0, 0, 0, 1);
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL overflow_clr got %b want 0", overflow_o); end
    cycle(1, 32'h1234_5678, 0, 1);
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL overflow_clr_set got %b want 1", overflow_o); end
    cycle(0, 0, 0, 1);
    while (q.size() > 0) begin
      cycle(0, 0, 1, 0);
      tests++; if (data_o !== m_data) begin fails++; $display("FAIL overflow_drain got %h want %h", data_o, m_data); end
    end
  endtask

  task automatic test_underflow();
    cycle(1, 32'h0AAA_AAAA, 1, 0);
    tests++; if (underflow_o !== 1'b1 || count_o !== 5'd1 || rd_valid_o !== 1'b0) begin fails++;
      $display("FAIL underflow got unf=%b cnt=%0d vld=%b want 1 1 0", underflow_o, count_o, rd_valid_o); end
    cycle(0, 0, 1, 1);
    tests++; if (data_o !== 32'h0AAA_AAAA || rd_valid_o !== 1'b1) begin fails++;
      $display("FAIL underflow_read got %b %h want 1 0aaaaaaa", rd_valid_o, data_o); end
    tests++; if (underflow_o !== 1'b0) begin fails++; $display("FAIL underflow_clr got %b want 0", underflow_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) cycle(1, $urandom, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, $urandom, 1, 0);
      tests++; if (count_o !== 5'd16 || data_o !== m_data || rd_valid_o !== 1'b1) begin fails++;
        $display("FAIL b2b got cnt=%0d %h vld=%b want 16 %h 1", count_o, data_o, rd_valid_o, m_data); end
    end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL b2b_ovf got %b want 0", overflow_o); end
    while (q.size() > 0) cycle(0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cycle(1, $urandom, 0, 0);
    tests++; if (count_o !== 5'd9) begin fails++; $display("FAIL mid_count got %0d want 9", count_o); end
    #2 rst = 1;
    #1;
    tests++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin fails++;
      $display("FAIL mid_reset got empty=%b cnt=%0d want 1 0", empty_o, count_o); end
    model_reset();
    @(negedge clk); rd_en_i = 1;
    @(negedge clk); rst = 0; rd_en_i = 0;
    tests++; if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", rd_valid_o); end
    cycle(0, 0, 1, 0);
    tests++; if (rd_valid_o !== 1'b0 || underflow_o !== 1'b1) begin fails++;
      $display("FAIL mid_stale got vld=%b unf=%b want 0 1", rd_valid_o, underflow_o); end
    cycle(1, 32'h5555_0001, 0, 1);
    cycle(1, 32'h5555_0002, 1, 0);
    tests++; if (data_o !== 32'h5555_0001 || rd_valid_o !== 1'b1) begin fails++;
      $display("FAIL mid_first got %b %h want 1 55550001", rd_valid_o, data_o); end
    cycle(0, 0, 1, 0);
  endtask

`ifdef GEN_FIFO_WATERMARK_EN
  task automatic test_watermark();
    for (int i = 0; i < 12; i++) begin
      cycle(1, $urandom, 0, 0);
      tests++; if (almost_full_o !== (q.size() >= 12) || almost_empty_o !== (q.size() <= 2)) begin fails++;
        $display("FAIL wm_fill got %b%b at %0d", almost_full_o, almost_empty_o, q.size()); end
    end
    while (q.size() > 2) begin
      cycle(0, 0, 1, 0);
      tests++; if (almost_full_o !== (q.size() >= 12) || almost_empty_o !== (q.size() <= 2)) begin fails++;
        $display("FAIL wm_drain got %b%b at %0d", almost_full_o, almost_empty_o, q.size()); end
    end
    while (q.size() > 0) cycle(0, 0, 1, 0);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);
      tests++;
      if (count_o !== 5'(q.size()) || full_o !== (q.size() == 16) || empty_o !== (q.size() == 0) ||
          rd_valid_o !== m_valid || data_o !== m_data || overflow_o !== m_ovf || underflow_o !== m_unf) begin
        fails++;
        $display("FAIL random got cnt=%0d f=%b e=%b v=%b d=%h o=%b u=%b want %0d %b %b %b %h %b %b",
          count_o, full_o, empty_o, rd_valid_o, data_o, overflow_o, underflow_o,
          q.size(), q.size() == 16, q.size() == 0, m_valid, m_data, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
`ifdef GEN_FIFO_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gen_sample_fifo.md
GEN_SAMPLE_FIFO -- requirements
Module: gen_sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the sample width; it matches the generator Q4.28 output.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, so that DEPTH = 2**ADDR_WIDTH = 16 entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default 12, giving the almost-full threshold in entries.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, giving the almost-empty threshold in entries.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port wr_en_i, input, 1 bit: write request; it connects to the generator wr_en_o.
REQ-008 The block SHALL have port data_i, input, DATA_WIDTH bits: signed sample to store.
REQ-009 The block SHALL have port rd_en_i, input, 1 bit: read request from the consumer.
REQ-010 The block SHALL have port clr_err_i, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port data_o, output, DATA_WIDTH bits: registered read data.
REQ-012 The block SHALL have port rd_valid_o, output, 1 bit: data_o holds a newly popped sample this cycle.
REQ-013 The block SHALL have port full_o, output, 1 bit, and port empty_o, output, 1 bit: status flags.
REQ-014 The block SHALL have port count_o, output, ADDR_WIDTH+1 bits: occupancy, range 0..DEPTH.
REQ-015 The block SHALL have port overflow_o, output, 1 bit, and port underflow_o, output, 1 bit: sticky error flags.
REQ-016 When GEN_FIFO_WATERMARK_EN is defined, the block SHALL also have port almost_full_o, output, 1 bit, and port almost_empty_o, output, 1 bit.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_WIDTH register array, addressed by wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits including a wrap bit.
REQ-018 A write SHALL be accepted when wr_en_i=1 and either full_o=0 or an accepted read occurs in the same cycle; it stores data_i at wr_ptr and increments wr_ptr modulo 2*DEPTH.
REQ-019 A read SHALL be accepted when rd_en_i=1 and empty_o=0; data_o SHALL take mem[rd_ptr] at the same edge, rd_valid_o SHALL be 1 for exactly the following cycle, and rd_ptr SHALL increment.
REQ-020 When no read is accepted, data_o SHALL hold its last value and rd_valid_o SHALL be 0.
REQ-021 When the FIFO is empty there SHALL be no write-to-read bypass: a read with a simultaneous write is rejected, and the written sample becomes readable from the next cycle.
REQ-022 empty_o SHALL be 1 when the pointers are equal including the wrap bit; full_o SHALL be 1 when the address bits are equal and the wrap bits differ.
REQ-023 count_o SHALL equal wr_ptr - rd_ptr (ADDR_WIDTH+1 bits), and all flags SHALL be registered or derived only from registered pointers.
REQ-024 count_o SHALL update by +1 for an accepted write only, -1 for an accepted read only, and 0 when both are accepted.
REQ-025 A write with wr_en_i=1 and full_o=1 and no accepted read SHALL be dropped with memory and pointers unchanged, and overflow_o SHALL be set next cycle.
REQ-026 A read with rd_en_i=1 and empty_o=1 SHALL be ignored, and underflow_o SHALL be set next cycle.
REQ-027 overflow_o and underflow_o SHALL remain set until clr_err_i=1; if clr_err_i=1 and a new error occur in the same cycle, the flag SHALL stay set.
REQ-028 Pointer wrap-around SHALL occur naturally from modulo arithmetic, with no special cases.

Reset
REQ-029 rst=1 SHALL asynchronously clear wr_ptr, rd_ptr, data_o, rd_valid_o, overflow_o and underflow_o to 0.
REQ-030 During reset, empty_o SHALL be 1, full_o SHALL be 0 and count_o SHALL be 0.
REQ-031 Memory contents SHALL NOT be reset, and stale data SHALL be unreachable after reset.
REQ-032 A reset asserted mid-stream SHALL discard all stored samples, and the first write after release SHALL be the first sample read.

Configuration
REQ-033 The macro GEN_FIFO_WATERMARK_EN, when defined, SHALL compile in almost_full_o = (count_o >= AF_LEVEL) and almost_empty_o = (count_o <= AE_LEVEL), both reset to 0 and 1 respectively.
REQ-034 When GEN_FIFO_WATERMARK_EN is undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Bench scenario: reset, write 16 samples 0x10000000..0x1000000F, then read 16 -> data_o returns the same values in order, full_o=1 after the 16th write, and empty_o=1 after the last read.
REQ-036 Bench scenario: full FIFO, wr_en_i=1 with data_i=0xDEADBEEF and no read -> sample dropped, overflow_o=1 next cycle, count_o stays 16; clr_err_i pulse -> overflow_o=0.
REQ-037 Bench scenario: empty FIFO, rd_en_i=1 and wr_en_i=1 with data_i=0x0AAAAAAA in the same cycle -> read rejected, underflow_o=1, count_o=1, and the next read returns 0x0AAAAAAA.
REQ-038 Bench scenario: full FIFO, simultaneous read and write for 40 cycles -> count_o stays 16, pointers wrap at least twice, and the output order is preserved.
REQ-039 Bench scenario: assert rst with count_o=9 -> empty_o=1 and count_o=0 immediately, with no rd_valid_o for the old data.
REQ-040 Bench scenario: with GEN_FIFO_WATERMARK_EN defined, fill to 12 -> almost_full_o=1; drain to 2 -> almost_empty_o=1.
